// File: rtl/hwpe_ctrl_tile_seq_pkg.sv
// Shared types for the HWPE tile sequencer: FSM encoding and the control/flag
// bundles exchanged with the HWPE control slave.
package hwpe_ctrl_package;

   localparam int unsigned TILE_SEQ_N_TILES_W = 16;
   localparam int unsigned TILE_SEQ_TIMEOUT_W = 20;

   typedef enum logic [1:0] {
      TS_IDLE   = 2'd0,
      TS_ISSUE  = 2'd1,
      TS_WAIT   = 2'd2,
      TS_FINISH = 2'd3
   } tile_seq_state_t;

   typedef struct packed {
      logic                          start;
      logic [TILE_SEQ_N_TILES_W-1:0] n_tiles;
      logic [TILE_SEQ_TIMEOUT_W-1:0] timeout_cycles;
   } ctrl_tile_seq_t;

   typedef struct packed {
      logic                          busy;
      logic                          done;
      logic                          timeout;
      logic [TILE_SEQ_N_TILES_W-1:0] tile_idx;
      logic                          last_tile;
   } flags_tile_seq_t;

endpackage

// File: rtl/hwpe_ctrl_tile_seq_if.sv
// Start/ready request plus done pulse between the tile sequencer (master)
// and the engine datapath (slave).
interface hwpe_ctrl_tile_seq_if;

   logic engine_start;
   logic engine_ready;
   logic engine_done;

   modport master (
      output engine_start,
      input  engine_ready,
      input  engine_done
   );

   modport slave (
      input  engine_start,
      output engine_ready,
      output engine_done
   );

endinterface

// File: rtl/hwpe_ctrl_tile_watchdog.sv
// Per-tile watchdog: saturating cycle counter that flags expiry when it
// reaches a non-zero threshold while enabled.
module hwpe_ctrl_tile_watchdog #(
   parameter int unsigned TIMEOUT_W = 20
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 en_i,
   input  logic [TIMEOUT_W-1:0] thr_i,
   output logic                 expired_o
);

   logic [TIMEOUT_W-1:0] cnt_q;

   // Counter: clear wins, then count while enabled, holding at all-ones.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clear_i) begin
         cnt_q <= '0;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_q <= cnt_q + TIMEOUT_W'(1);
      end else begin
         cnt_q <= cnt_q;
      end
   end

   assign expired_o = en_i && (thr_i != '0) && (cnt_q == thr_i);

endmodule

// File: rtl/hwpe_ctrl_tile_seq.sv
// Tile sequencer: splits one job trigger into n_tiles engine runs with a
// start/ready handshake per tile, a per-tile watchdog and one job-done pulse.
module hwpe_ctrl_tile_seq
   import hwpe_ctrl_package::*;
#(
   parameter int unsigned N_TILES_W = 16,
   parameter int unsigned TIMEOUT_W = 20
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 start_i,
   input  logic [N_TILES_W-1:0] n_tiles_i,
   input  logic [TIMEOUT_W-1:0] timeout_cycles_i,
   hwpe_ctrl_tile_seq_if.master eng,
   output logic [N_TILES_W-1:0] tile_idx_o,
   output logic                 last_tile_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 timeout_o
);

   localparam logic [1:0] IDLE   = TS_IDLE;
   localparam logic [1:0] ISSUE  = TS_ISSUE;
   localparam logic [1:0] WAIT   = TS_WAIT;
   localparam logic [1:0] FINISH = TS_FINISH;

   logic [1:0]           state_q, state_d;
   logic [N_TILES_W-1:0] tile_idx_q, tile_idx_d;
   logic [N_TILES_W-1:0] n_tiles_q, n_tiles_d;
   logic                 timeout_q, timeout_d;
   logic                 wd_clear_s;
   logic                 expired_s;
   logic                 last_tile_s;

   // Full-width compare; with n_tiles_q == 0 the wrap to all-ones never matches.
   assign last_tile_s = (tile_idx_q == (n_tiles_q - N_TILES_W'(1)));

   hwpe_ctrl_tile_watchdog #(
      .TIMEOUT_W (TIMEOUT_W)
   ) i_watchdog (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_i   (wd_clear_s),
      .en_i      (state_q == WAIT),
      .thr_i     (timeout_cycles_i),
      .expired_o (expired_s)
   );

   // Next-state logic; clear overrides every transition.
   always_comb begin
      state_d    = state_q;
      tile_idx_d = tile_idx_q;
      n_tiles_d  = n_tiles_q;
      timeout_d  = timeout_q;
      wd_clear_s = 1'b0;
      if (clear_i) begin
         state_d    = IDLE;
         tile_idx_d = '0;
         n_tiles_d  = '0;
         timeout_d  = 1'b0;
         wd_clear_s = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  n_tiles_d  = n_tiles_i;
                  tile_idx_d = '0;
                  timeout_d  = 1'b0;
                  state_d    = (n_tiles_i == '0) ? FINISH : ISSUE;
               end else begin
                  state_d = IDLE;
               end
            end
            ISSUE: begin
               if (eng.engine_ready) begin
                  wd_clear_s = 1'b1;
                  state_d    = WAIT;
               end else begin
                  state_d = ISSUE;
               end
            end
            WAIT: begin
               // A done in the expiry cycle wins and leaves the timeout flag alone.
               if (eng.engine_done) begin
                  if (last_tile_s) begin
                     state_d = FINISH;
                  end else begin
                     tile_idx_d = tile_idx_q + N_TILES_W'(1);
                     state_d    = ISSUE;
                  end
               end else if (expired_s) begin
                  timeout_d = 1'b1;
                  state_d   = FINISH;
               end else begin
                  state_d = WAIT;
               end
            end
            FINISH: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         tile_idx_q <= '0;
         n_tiles_q  <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tile_idx_q <= tile_idx_d;
         n_tiles_q  <= n_tiles_d;
         timeout_q  <= timeout_d;
      end
   end

   assign eng.engine_start = (state_q == ISSUE);
   assign busy_o           = (state_q != IDLE);
   assign done_o           = (state_q == FINISH);
   assign timeout_o        = timeout_q;
   assign tile_idx_o       = tile_idx_q;
   assign last_tile_o      = last_tile_s;

endmodule

// File: tb/tb_hwpe_ctrl_tile_seq.sv
// Randomized self-checking bench for hwpe_ctrl_tile_seq; a job-level engine
// model predicts every output cycle by cycle.
module tb_hwpe_ctrl_tile_seq;

   localparam int unsigned NW = 16;
   localparam int unsigned TW = 20;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clear;
   logic          start;
   logic [NW-1:0] n_tiles;
   logic [TW-1:0] thr;
   logic [NW-1:0] tile_idx;
   logic          last_tile;
   logic          busy;
   logic          done;
   logic          timeout;

   hwpe_ctrl_tile_seq_if eng_if ();

   hwpe_ctrl_tile_seq #(
      .N_TILES_W (NW),
      .TIMEOUT_W (TW)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .clear_i          (clear),
      .start_i          (start),
      .n_tiles_i        (n_tiles),
      .timeout_cycles_i (thr),
      .eng              (eng_if),
      .tile_idx_o       (tile_idx),
      .last_tile_o      (last_tile),
      .busy_o           (busy),
      .done_o           (done),
      .timeout_o        (timeout)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   // job-level model: latched tile count, current tile, sticky timeout
   int m_n      = 0;
   int m_idx    = 0;
   bit m_to     = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_outs(input string tag, input bit es, input bit bsy, input bit dn);
      bit lst;
      lst = (m_n != 0) && (m_idx == m_n - 1);
      check_eq({tag, ".engine_start"}, {31'd0, eng_if.engine_start}, {31'd0, es});
      check_eq({tag, ".busy"},         {31'd0, busy},    {31'd0, bsy});
      check_eq({tag, ".done"},         {31'd0, done},    {31'd0, dn});
      check_eq({tag, ".timeout"},      {31'd0, timeout}, {31'd0, m_to});
      check_eq({tag, ".tile_idx"},     {16'd0, tile_idx}, m_idx);
      check_eq({tag, ".last_tile"},    {31'd0, last_tile}, {31'd0, lst});
   endtask

   function automatic bit coin(input bit en);
      return en && ($urandom_range(0, 1) == 1);
   endfunction

   // rw/dd < 0 pick random ready wait / done delay per tile
   task automatic run_job(input int n, input int thr_v, input int rw, input int dd, input bit stray);
      int  w;
      int  d;
      bit  ended;
      n_tiles = n[NW-1:0];
      thr     = thr_v[TW-1:0];
      start   = 1'b1;
      expect_outs("pre_start", 1'b0, 1'b0, 1'b0);
      step();
      start   = 1'b0;
      n_tiles = NW'($urandom);
      m_n     = n;
      m_idx   = 0;
      m_to    = 1'b0;
      ended   = 1'b0;
      for (int i = 0; i < n && !ended; i++) begin
         m_idx = i;
         w = (rw < 0) ? $urandom_range(0, 3) : rw;
         for (int c = 0; c <= w; c++) begin
            expect_outs("issue", 1'b1, 1'b1, 1'b0);
            eng_if.engine_ready = (c == w);
            eng_if.engine_done  = coin(stray);
            start               = coin(stray);
            step();
         end
         eng_if.engine_ready = 1'b0;
         eng_if.engine_done  = 1'b0;
         start               = 1'b0;
         d = (dd < 0) ? $urandom_range(0, 6) : dd;
         for (int j = 0; ; j++) begin
            expect_outs("wait", 1'b0, 1'b1, 1'b0);
            start = coin(stray);
            if (j == d) begin
               eng_if.engine_done = 1'b1;
               step();
               eng_if.engine_done = 1'b0;
               start = 1'b0;
               break;
            end
            if (thr_v != 0 && j == thr_v) begin
               step();
               start = 1'b0;
               m_to  = 1'b1;
               ended = 1'b1;
               break;
            end
            if (j > 4000) begin
               check_eq("wait_bound", 32'd1, 32'd0);
               ended = 1'b1;
               break;
            end
            step();
            start = 1'b0;
         end
      end
      expect_outs("finish", 1'b0, 1'b1, 1'b1);
      step();
      expect_outs("post_idle", 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      clear = 1'b0;
      start = 1'b0;
      n_tiles = '0;
      thr = '0;
      eng_if.engine_ready = 1'b0;
      eng_if.engine_done  = 1'b0;
      #1;
      expect_outs("reset", 1'b0, 1'b0, 1'b0);
      step();
      step();
      rst_n = 1'b1;
      step();
      expect_outs("idle", 1'b0, 1'b0, 1'b0);

      // nominal: 3 tiles, done 5 cycles after each handshake
      run_job(3, 0, 0, 4, 1'b0);
      // backpressure: ready low for 4 cycles per tile
      run_job(2, 0, 4, -1, 1'b0);
      // zero-tile job
      run_job(0, 0, 0, 0, 1'b0);
      // stray starts and dones mid-job
      run_job(4, 0, -1, -1, 1'b1);

      // watchdog expiry, then sticky until the next start
      run_job(1, 10, 0, 100000, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step();
         expect_outs("sticky", 1'b0, 1'b0, 1'b0);
      end
      run_job(2, 0, -1, -1, 1'b0);
      // done in the expiry cycle wins
      run_job(1, 6, 0, 6, 1'b0);

      // randomized jobs, including expiring ones
      for (int r = 0; r < 25; r++) begin
         run_job($urandom_range(0, 4), $urandom_range(0, 8), -1, -1, coin(1'b1));
      end

      // clear in WAIT of tile 1 of 4
      run_job(1, 3, 0, 50, 1'b0);
      n_tiles = NW'(4);
      thr     = '0;
      start   = 1'b1;
      step();
      start = 1'b0;
      m_n = 4; m_idx = 0; m_to = 1'b0;
      eng_if.engine_ready = 1'b1;
      step();
      eng_if.engine_ready = 1'b0;
      eng_if.engine_done  = 1'b1;
      step();
      eng_if.engine_done  = 1'b0;
      m_idx = 1;
      eng_if.engine_ready = 1'b1;
      step();
      eng_if.engine_ready = 1'b0;
      expect_outs("pre_clear", 1'b0, 1'b1, 1'b0);
      clear = 1'b1;
      step();
      clear = 1'b0;
      m_n = 0; m_idx = 0;
      expect_outs("clear", 1'b0, 1'b0, 1'b0);
      step();
      expect_outs("post_clear", 1'b0, 1'b0, 1'b0);

      // async reset while in ISSUE
      n_tiles = NW'(3);
      start   = 1'b1;
      step();
      start = 1'b0;
      m_n = 3; m_idx = 0;
      expect_outs("pre_reset", 1'b1, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      m_n = 0; m_idx = 0; m_to = 1'b0;
      expect_outs("async_reset", 1'b0, 1'b0, 1'b0);
      step();
      rst_n = 1'b1;
      step();
      expect_outs("after_reset", 1'b0, 1'b0, 1'b0);
      run_job(2, 0, -1, -1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
